// File: rtl/mux4_rr_sched.sv
// mux4_rr_sched: round-robin scheduler sharing one 4:1 data mux among four
// requesters (a,b,c,d). It grants one requester at a time, bounds its tenure
// to QUANTUM beats while others wait, and registers the selected data.
//
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   async active-low reset, synchronous release
//   req[3:0]  in   request lines, bit0=a .. bit3=d
//   a,b,c,d   in   requester data, DATA_W each
//   gnt[3:0]  out  registered one-hot grant, 0 when idle
//   s[1:0]    out  registered mux select = granted index (holds when idle)
//   busy      out  high while in GRANT state
//   dout      out  registered mux output
//   dout_vld  out  dout carries a beat this cycle
module mux4_rr_sched #(
   parameter int DATA_W  = 8,
   parameter int QUANTUM = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        req,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   input  logic [DATA_W-1:0] d,
   output logic [3:0]        gnt,
   output logic [1:0]        s,
   output logic              busy,
   output logic [DATA_W-1:0] dout,
   output logic              dout_vld
);

   localparam int CNT_W = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QUANTUM - 1);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [3:0]        gnt_q, gnt_d;
   logic [1:0]        s_q, s_d;
   logic [1:0]        last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] dout_q, dout_d;
   logic              vld_q, vld_d;

   logic [3:0]        others;
   logic [1:0]        win;
   logic [DATA_W-1:0] mux_out;

   // First requester found scanning ptr+1, ptr+2, ... wrapping mod 4.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
      logic [1:0] idx;
      logic       found;
      rr_pick = ptr;
      found   = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && r[idx]) begin
            rr_pick = idx;
            found   = 1'b1;
         end
      end
   endfunction

   always_comb begin
      mux_out = a;
      case (s_q)
         2'd0: mux_out = a;
         2'd1: mux_out = b;
         2'd2: mux_out = c;
         2'd3: mux_out = d;
         default: mux_out = a;
      endcase
   end

   // gnt_q is zero in IDLE, so one masked search serves both the initial
   // grant and the handoff; last_q equals the owner while granted.
   assign others = req & ~gnt_q;
   assign win    = rr_pick(others, last_q);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         s_q     <= '0;
         last_q  <= 2'd3;
         cnt_q   <= '0;
         dout_q  <= '0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         s_q     <= s_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         vld_q   <= vld_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      s_d     = s_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      vld_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d = GRANT;
               gnt_d   = 4'b0001 << win;
               s_d     = win;
               last_d  = win;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            if (!req[s_q]) begin
               // Release: hand off without an idle cycle when anyone waits.
               if (|others) begin
                  gnt_d  = 4'b0001 << win;
                  s_d    = win;
                  last_d = win;
                  cnt_d  = '0;
               end else begin
                  state_d = IDLE;
                  gnt_d   = '0;
               end
            end else begin
               dout_d = mux_out;
               vld_d  = 1'b1;
               if (cnt_q == CNT_MAX && |others) begin
                  // Quantum used up with a waiter: this beat is the last one.
                  gnt_d  = 4'b0001 << win;
                  s_d    = win;
                  last_d = win;
                  cnt_d  = '0;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      gnt      = gnt_q;
      s        = s_q;
      busy     = (state_q == GRANT);
      dout     = dout_q;
      dout_vld = vld_q;
   end

endmodule
